// File: rtl/pcs_tx_sched_64b66b_pkg.sv
// pcs_64b66b_pkg: shared sync headers, IDLE block type, default sizes and scheduler state type
package pcs_64b66b_pkg;
  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;
  localparam logic [7:0] BT_IDLE = 8'h1E;
  localparam int GB_PERIOD_DEF = 32;
  localparam int WARMUP_DEF = 16;
  localparam int SEQ_W = $clog2(GB_PERIOD_DEF + 1);
  typedef enum logic {WARMUP, RUN} tx_sched_state_e;
endpackage

// File: rtl/pcs_tx_sched_64b66b_if.sv
// pcs_tx_sched_64b66b_if: upstream block handshake plus scrambler-side outputs
// master drives tx_en_i/valid_i/ctrl_i/data_i; slave (the scheduler) drives ready_o and scram_*/head_o/gb_pause_o
interface pcs_tx_sched_64b66b_if #(
  parameter int BLOCKS = 8,
  parameter int LEN = 8
);
  logic tx_en_i;
  logic valid_i;
  logic ctrl_i;
  logic [BLOCKS*LEN-1:0] data_i;
  logic ready_o;
  logic scram_valid_o;
  logic [BLOCKS*LEN-1:0] scram_data_o;
  logic [1:0] head_o;
  logic gb_pause_o;
  modport master(
    output tx_en_i, valid_i, ctrl_i, data_i,
    input ready_o, scram_valid_o, scram_data_o, head_o, gb_pause_o
  );
  modport slave(
    input tx_en_i, valid_i, ctrl_i, data_i,
    output ready_o, scram_valid_o, scram_data_o, head_o, gb_pause_o
  );
endinterface

// File: rtl/pcs_tx_sched_64b66b_gb_seq.sv
// gb_seq_cnt: free-running 0..GB_PERIOD gearbox sequence with registered pause flag
// ports: clk, nreset (async active-low), pause_o (high while the sequence sits at GB_PERIOD)
module gb_seq_cnt
  import pcs_64b66b_pkg::*;
#(
  parameter int GB_PERIOD = GB_PERIOD_DEF
) (
  input  logic clk,
  input  logic nreset,
  output logic pause_o
);
  localparam int SW = $clog2(GB_PERIOD + 1);
  logic [SW-1:0] seq_q;
  // pause_o is decoded one step early so it is high exactly while seq_q==GB_PERIOD
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      seq_q <= '0;
      pause_o <= 1'b0;
    end else begin
      seq_q <= (seq_q == SW'(GB_PERIOD)) ? '0 : seq_q + 1'b1;
      pause_o <= (seq_q == SW'(GB_PERIOD - 1));
    end
  end
endmodule

// File: rtl/pcs_tx_sched_64b66b.sv
// pcs_tx_sched_64b66b: TX PCS scheduler feeding the scrambler with headers, IDLE fill and gearbox pauses
// ports: clk, nreset (async active-low), bus (slave side of pcs_tx_sched_64b66b_if)
module pcs_tx_sched_64b66b
  import pcs_64b66b_pkg::*;
#(
  parameter int BLOCKS = 8,
  parameter int LEN = 8,
  parameter int WARMUP_CYCLES = WARMUP_DEF,
  parameter int GB_PERIOD = GB_PERIOD_DEF
) (
  input logic clk,
  input logic nreset,
  pcs_tx_sched_64b66b_if.slave bus
);
  localparam int W = BLOCKS * LEN;
  localparam int WW = $clog2(WARMUP_CYCLES + 1);
  tx_sched_state_e state_q, state_d;
  logic [WW-1:0] warm_q, warm_d;
  logic pause, accept, warm_last;
  gb_seq_cnt #(.GB_PERIOD(GB_PERIOD)) u_seq (
    .clk(clk),
    .nreset(nreset),
    .pause_o(pause)
  );
  always_comb begin
    warm_last = (state_q == WARMUP) && bus.tx_en_i && !pause && (warm_q == WW'(WARMUP_CYCLES - 1));
    state_d = !bus.tx_en_i ? WARMUP : warm_last ? RUN : state_q;
    warm_d = (!bus.tx_en_i || state_q == RUN || warm_last) ? '0 : pause ? warm_q : warm_q + 1'b1;
    bus.ready_o = (state_q == RUN) && bus.tx_en_i && !pause;
    accept = bus.valid_i && bus.ready_o;
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= WARMUP;
      warm_q <= '0;
    end else begin
      state_q <= state_d;
      warm_q <= warm_d;
    end
  end
  // on a pause cycle head and data keep their previous value; only valid drops
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      bus.scram_valid_o <= 1'b0;
      bus.gb_pause_o <= 1'b0;
      bus.head_o <= 2'b00;
      bus.scram_data_o <= '0;
    end else begin
      bus.scram_valid_o <= !pause;
      bus.gb_pause_o <= pause;
      if (!pause) begin
        bus.head_o <= (accept && !bus.ctrl_i) ? SYNC_DATA : SYNC_CTRL;
        bus.scram_data_o <= accept ? bus.data_i : W'(BT_IDLE);
      end
    end
  end
endmodule
